execute_md: RTL and testbench
=============================

# execute_md

Parametrised execute stage for the RISC-V pipeline: registers the ID/EX bundle, resolves MEM/WB forwarding, and computes single-cycle ALU results. It adds an iterative RV-M multiply/divide unit with a valid/ready stall handshake toward decode. It sits between decode and the memory stage, and is generic in datapath width (RV32/RV64).

## Interface
- XLEN, 64, datapath width; legal values are 32 and 64.
- IMM_W, 32, immediate width; sign-extended to XLEN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  decode presents an instruction.
- ready_o  out  1  stage accepts an instruction this cycle.
- alu_src_i  in  1  selects operand 2: 1 = immediate, 0 = rs2.
- alu_op_i  in  2  ALU class from main control.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- rs1_i, rs2_i, rd_i  in  5 each  register indices.
- imm_i  in  IMM_W  immediate.
- rs1_data_i, rs2_data_i  in  XLEN each  register-file read data.
- mem_reg_write_i, mem_rd_i, mem_result_i  in  1/5/XLEN  MEM-stage writeback info.
- wb_reg_write_i, wb_rd_i, wb_result_i  in  1/5/XLEN  WB-stage writeback info.
- valid_o  out  1  result valid this cycle.
- rd_o  out  5  destination register.
- alu_result_o  out  XLEN  ALU or M-extension result.
- wr_ram_data_o  out  XLEN  forwarded rs2 value, used as store data.

## Operation
- **Capture:** all inputs are registered into the EX register when `valid_i && ready_o`.
  - If `valid_i` is low in that cycle, the EX valid bit clears.
- **Forwarding:**
  - Per source, the MEM match (`mem_reg_write_i`, `mem_rd_i == rs`, `rs != 0`) wins over the WB match. Otherwise the registered file data is used.
  - The mux is fully specified, so there are no latches.
- **Operands:**
  - op1 = forwarded rs1.
  - op2 = sign-extended immediate if `alu_src`, else forwarded rs2.
  - `wr_ram_data_o` is always forwarded rs2, never the immediate.
- **Op select:** an M op is `alu_op == 2'b10 && funct7 == 7'b0000001`. Anything else goes to the single-cycle ALU.
- **M ops** (funct3 000–111): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Signed operands are converted to magnitudes.
  - Multiply uses radix-2 shift-add; divide uses restoring division.
  - The result is sign-corrected at DONE.
- **M-op special cases:**
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (MIN / −1): quotient = MIN, remainder = 0.
- **muldiv FSM:**
  - IDLE → BUSY when the EX register holds a valid M op. Forwarded operands are latched here and are not re-forwarded afterwards. The counter loads XLEN−1.
  - BUSY: one bit per cycle; the counter decrements. BUSY → DONE when the counter reaches 0.
  - DONE → IDLE after one cycle.
  - Divide-by-zero and overflow go IDLE → DONE directly.
- **Output and handshake:**
  - `valid_o` = EX valid && (not M op || FSM == DONE).
  - `ready_o` = !(EX valid && M op && FSM != DONE).
- **Reset values:**
  - All EX registers reset to 0 and the FSM resets to IDLE.
  - Hence `valid_o` = 0, `ready_o` = 1, `rd_o` = 0, `alu_result_o` = 0, `wr_ram_data_o` = 0.

## Timing
- **ALU ops:** `valid_o` in the cycle after capture; `alu_result_o` is combinational from the EX register. `ready_o` stays 1.
- **M ops, general case:** capture at cycle t.
  - BUSY during t+1 .. t+XLEN; DONE at t+XLEN+1.
  - `valid_o` is 1 only at t+XLEN+1 (XLEN=64: t+65).
  - `ready_o` is 0 during t+1 .. t+XLEN.
- **M ops, special cases:** DONE at t+2.
- **DONE cycle:** `ready_o` = 1, so the next instruction is captured in the same cycle the M result leaves.
- **Stall:** while `ready_o` = 0, decode holds `valid_i` and its bundle stable. Downstream sees `valid_o` = 0 (bubble).
- **Reset mid-operation:** the FSM aborts to IDLE and EX valid clears. No partial result appears.
- **rd == x0:** never forwards. The result is still produced; suppressing the write is the register file's job.

## Structure
- `cpu_pkg` holds:
  - `alu_ctrl_e` (ALU control codes);
  - `md_op_e` (the 8 M ops);
  - `fwd_sel_e` (REG, MEM, WB);
  - `md_state_e` (IDLE, BUSY, DONE);
  - the constant `FUNCT7_MULDIV = 7'b0000001`.
- One sub-module, `muldiv_unit #(XLEN)`, with:
  - ports `start_i`, `op_i`, `a_i`, `b_i`, `done_o`, `result_o`;
  - the FSM, counter, and shift registers.
- ALU control, ALU and forwarding logic stay inline in `execute_md`.

## Test plan
- **Forwarding priority:** ADD, rs1=5. MEM writes x5 = 10, WB writes x5 = 20, file x5 = 1, rs2 data = 3. Expect `alu_result_o` = 13 one cycle later.
- **x0 suppression:** ADD, rs1=0, MEM rd=0 writes 99, file value 0, imm = 4 with `alu_src` = 1. Expect result 4.
- **MUL (XLEN=64):** 7 × −3. Expect `ready_o` = 0 for 64 cycles, `valid_o` at t+65, result 0xFFFF_FFFF_FFFF_FFEB.
- **Divide special cases:**
  - DIV 100 / 0 → all ones, `valid_o` at t+2.
  - REM 100 / 0 → 100.
  - DIV MIN / −1 → 0x8000_0000_0000_0000.
  - REM MIN / −1 → 0.
- **Reset mid-divide:** `rst_i` pulsed 10 cycles into a DIVU. Next cycle: `valid_o` = 0 and `ready_o` = 1. A following ADD 2+2 gives 4.
- **MULHU (XLEN=32):** 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE at t+33. A back-to-back ADD is captured in the DONE cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the execute stage: ALU
//                control codes, RV-M operation codes, forwarding selects,
//                multiply/divide FSM states and the ALU control decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // ALU class produced by the main control unit
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_e;

    // Encoding equals funct3 of the RV-M instructions
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // funct7[5] distinguishes SUB/SRA; SUB only exists in R-type encoding,
    // for I-type funct7 is the upper immediate and only matters for SRAI.
    function automatic alu_ctrl_e alu_ctrl_decode(
        input logic [1:0] alu_op,
        input logic [2:0] funct3,
        input logic [6:0] funct7
    );
        alu_ctrl_e ctrl;
        ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_BRANCH: ctrl = ALU_SUB;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    3'b000: ctrl = (alu_op == ALUOP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001: ctrl = ALU_SLL;
                    3'b010: ctrl = ALU_SLT;
                    3'b011: ctrl = ALU_SLTU;
                    3'b100: ctrl = ALU_XOR;
                    3'b101: ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: ctrl = ALU_OR;
                    3'b111: ctrl = ALU_AND;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV-M multiply/divide. Radix-2 shift-add multiply,
//                restoring division, one bit per cycle on magnitudes with a
//                sign correction applied to the final result.
//  Ports       : clk_i, rst_i   - clock, synchronous active-high reset
//                start_i        - a valid M op is waiting (sampled in IDLE)
//                op_i           - M operation (funct3)
//                a_i, b_i       - forwarded operands, latched on start
//                done_o         - FSM is in DONE, result_o is valid
//                result_o       - sign-corrected result
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;     // product high / partial remainder
    logic [XLEN-1:0]  r_lo;     // multiplier bits / quotient bits
    logic [XLEN-1:0]  r_m;      // multiplicand or divisor magnitude
    md_op_e           r_op;
    logic             r_neg_q;  // negate product or quotient
    logic             r_neg_r;  // negate remainder

    // One iteration. Multiply: conditionally add the multiplicand to the high
    // half, then shift the whole {hi,lo} right. Divide: shift {rem,quot}
    // left, trial-subtract the divisor and keep it only if non-negative.
    function automatic logic [2*XLEN-1:0] md_step(
        input logic            is_div,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] m
    );
        logic [XLEN:0]     sum;
        logic [XLEN:0]     trial;
        logic [2*XLEN-1:0] nxt;
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        trial = {hi, lo[XLEN-1]} - {1'b0, m};
        if (!is_div) begin
            nxt = {sum, lo[XLEN-1:1]};
        end else if (trial[XLEN]) begin
            nxt = {hi[XLEN-2:0], lo[XLEN-1], lo[XLEN-2:0], 1'b0};
        end else begin
            nxt = {trial[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end
        return nxt;
    endfunction

    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic [2*XLEN-1:0] w_first;

    // MUL only needs the low word, which is sign-agnostic, so it runs unsigned
    assign w_is_div   = op_i[2];
    assign w_a_signed = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
    assign w_b_signed = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
    assign w_a_neg    = w_a_signed && a_i[XLEN-1];
    assign w_b_neg    = w_b_signed && b_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? -a_i : a_i;
    assign w_b_mag    = w_b_neg ? -b_i : b_i;
    assign w_div_zero = w_is_div && (b_i == '0);
    assign w_ovf      = ((op_i == MD_DIV) || (op_i == MD_REM)) && (a_i == MIN_VAL) && (b_i == '1);

    // The first bit is processed on the start edge so that XLEN bits finish
    // after XLEN-1 BUSY cycles.
    assign w_first = w_is_div ? md_step(1'b1, '0, w_a_mag, w_b_mag)
                              : md_step(1'b0, '0, w_b_mag, w_a_mag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_op    <= MD_MUL;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start_i) begin
                        r_op <= op_i;
                        if (w_div_zero) begin
                            // quotient all ones, remainder = raw dividend
                            r_hi    <= a_i;
                            r_lo    <= '1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= MD_DONE;
                        end else if (w_ovf) begin
                            r_hi    <= '0;
                            r_lo    <= MIN_VAL;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= MD_DONE;
                        end else begin
                            {r_hi, r_lo} <= w_first;
                            r_m     <= w_is_div ? w_b_mag : w_a_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= CNT_LOAD;
                            r_state <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    {r_hi, r_lo} <= md_step(r_op[2], r_hi, r_lo, r_m);
                    r_cnt        <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= MD_DONE;
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quot = r_neg_q ? -r_lo : r_lo;
    assign w_rem  = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        result_o = '0;
        case (r_op)
            MD_MUL:                        result_o = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result_o = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               result_o = w_quot;
            MD_REM, MD_REMU:               result_o = w_rem;
            default:                       result_o = '0;
        endcase
    end

    assign done_o = (r_state == MD_DONE);

endmodule
`default_nettype wire

// File: rtl/execute_md.sv
`default_nettype none
// ============================================================================
//  Module      : execute_md
//  Description : RISC-V execute stage. Registers the ID/EX bundle, forwards
//                from MEM/WB, computes single-cycle ALU results and runs RV-M
//                ops on an iterative unit, stalling decode while it is busy.
//  Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//                valid_i / ready_o     - decode handshake
//                alu_src_i..imm_i      - decoded instruction fields
//                rs1_data_i, rs2_data_i- register-file read data
//                mem_*_i, wb_*_i       - writeback info for forwarding
//                valid_o, rd_o         - result valid and destination
//                alu_result_o          - ALU or M-extension result
//                wr_ram_data_o         - forwarded rs2 (store data)
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_md
    import cpu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int IMM_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             alu_src_i,
    input  logic [1:0]       alu_op_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [4:0]       rd_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             mem_reg_write_i,
    input  logic [4:0]       mem_rd_i,
    input  logic [XLEN-1:0]  mem_result_i,
    input  logic             wb_reg_write_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_result_i,
    output logic             valid_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic [XLEN-1:0]  wr_ram_data_o
);

    localparam int SHAMT_W = $clog2(XLEN);

    // ---------------------------------------------------------------- EX reg
    logic             r_valid;
    logic             r_alu_src;
    logic [1:0]       r_alu_op;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [IMM_W-1:0] r_imm;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_alu_src  <= 1'b0;
            r_alu_op   <= '0;
            r_funct3   <= '0;
            r_funct7   <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (ready_o) begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_alu_src  <= alu_src_i;
                r_alu_op   <= alu_op_i;
                r_funct3   <= funct3_i;
                r_funct7   <= funct7_i;
                r_rs1      <= rs1_i;
                r_rs2      <= rs2_i;
                r_rd       <= rd_i;
                r_imm      <= imm_i;
                r_rs1_data <= rs1_data_i;
                r_rs2_data <= rs2_data_i;
            end
        end
    end

    // ------------------------------------------------------------ forwarding
    // MEM holds the younger value, so it wins; x0 never forwards.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        fwd_sel_e sel;
        sel = FWD_REG;
        if (rs != 5'd0) begin
            if (mem_we && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_we && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    fwd_sel_e        w_rs1_sel;
    fwd_sel_e        w_rs2_sel;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    assign w_rs1_sel = fwd_select(r_rs1, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);
    assign w_rs2_sel = fwd_select(r_rs2, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);

    always_comb begin
        w_rs1_fwd = r_rs1_data;
        case (w_rs1_sel)
            FWD_MEM: w_rs1_fwd = mem_result_i;
            FWD_WB:  w_rs1_fwd = wb_result_i;
            default: w_rs1_fwd = r_rs1_data;
        endcase
    end

    always_comb begin
        w_rs2_fwd = r_rs2_data;
        case (w_rs2_sel)
            FWD_MEM: w_rs2_fwd = mem_result_i;
            FWD_WB:  w_rs2_fwd = wb_result_i;
            default: w_rs2_fwd = r_rs2_data;
        endcase
    end

    // -------------------------------------------------------------- operands
    logic [XLEN-1:0] w_imm_sx;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    assign w_imm_sx = XLEN'($signed(r_imm));
    assign w_op1    = w_rs1_fwd;
    assign w_op2    = r_alu_src ? w_imm_sx : w_rs2_fwd;

    // ------------------------------------------------------------------- ALU
    alu_ctrl_e          w_alu_ctrl;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_alu_result;

    assign w_alu_ctrl = alu_ctrl_decode(r_alu_op, r_funct3, r_funct7);
    assign w_shamt    = w_op2[SHAMT_W-1:0];

    always_comb begin
        w_alu_result = '0;
        case (w_alu_ctrl)
            ALU_ADD:  w_alu_result = w_op1 + w_op2;
            ALU_SUB:  w_alu_result = w_op1 - w_op2;
            ALU_SLL:  w_alu_result = w_op1 << w_shamt;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (w_op1 < w_op2)};
            ALU_XOR:  w_alu_result = w_op1 ^ w_op2;
            ALU_SRL:  w_alu_result = w_op1 >> w_shamt;
            ALU_SRA:  w_alu_result = $signed(w_op1) >>> w_shamt;
            ALU_OR:   w_alu_result = w_op1 | w_op2;
            ALU_AND:  w_alu_result = w_op1 & w_op2;
            default:  w_alu_result = w_op1 + w_op2;
        endcase
    end

    // ------------------------------------------------------------ M extension
    logic            w_is_m;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;

    assign w_is_m = (r_alu_op == ALUOP_RTYPE) && (r_funct7 == FUNCT7_MULDIV);

    muldiv_unit #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (r_valid && w_is_m),
        .op_i     (md_op_e'(r_funct3)),
        .a_i      (w_op1),
        .b_i      (w_op2),
        .done_o   (w_md_done),
        .result_o (w_md_result)
    );

    // ---------------------------------------------------------------- outputs
    assign ready_o       = !(r_valid && w_is_m && !w_md_done);
    assign valid_o       = r_valid && (!w_is_m || w_md_done);
    assign rd_o          = r_rd;
    assign alu_result_o  = w_is_m ? w_md_result : w_alu_result;
    assign wr_ram_data_o = w_rs2_fwd;

endmodule
`default_nettype wire

// File: tb/tb_execute_md.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_md
//  Description : Directed self-checking bench for execute_md, with one
//                XLEN=64 instance and one XLEN=32 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_md;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    // ----------------------------------------------------------- XLEN = 64
    logic        valid_i, ready_o, alu_src_i, valid_o;
    logic [1:0]  alu_op_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rs1_i, rs2_i, rd_i, rd_o;
    logic [31:0] imm_i;
    logic [63:0] rs1_data_i, rs2_data_i, alu_result_o, wr_ram_data_o;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [63:0] mem_res, wb_res;

    execute_md #(.XLEN(64), .IMM_W(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .alu_src_i       (alu_src_i),
        .alu_op_i        (alu_op_i),
        .funct3_i        (funct3_i),
        .funct7_i        (funct7_i),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .rd_i            (rd_i),
        .imm_i           (imm_i),
        .rs1_data_i      (rs1_data_i),
        .rs2_data_i      (rs2_data_i),
        .mem_reg_write_i (mem_we),
        .mem_rd_i        (mem_rd),
        .mem_result_i    (mem_res),
        .wb_reg_write_i  (wb_we),
        .wb_rd_i         (wb_rd),
        .wb_result_i     (wb_res),
        .valid_o         (valid_o),
        .rd_o            (rd_o),
        .alu_result_o    (alu_result_o),
        .wr_ram_data_o   (wr_ram_data_o)
    );

    // ----------------------------------------------------------- XLEN = 32
    logic        v32_valid_i, v32_ready_o, v32_alu_src, v32_valid_o;
    logic [1:0]  v32_alu_op;
    logic [2:0]  v32_funct3;
    logic [6:0]  v32_funct7;
    logic [4:0]  v32_rs1, v32_rs2, v32_rd, v32_rd_o;
    logic [31:0] v32_imm, v32_d1, v32_d2, v32_result, v32_wr_ram;
    logic [31:0] v32_zero;

    assign v32_zero = '0;

    execute_md #(.XLEN(32), .IMM_W(32)) dut32 (
        .clk_i           (clk),
        .rst_i           (rst),
        .valid_i         (v32_valid_i),
        .ready_o         (v32_ready_o),
        .alu_src_i       (v32_alu_src),
        .alu_op_i        (v32_alu_op),
        .funct3_i        (v32_funct3),
        .funct7_i        (v32_funct7),
        .rs1_i           (v32_rs1),
        .rs2_i           (v32_rs2),
        .rd_i            (v32_rd),
        .imm_i           (v32_imm),
        .rs1_data_i      (v32_d1),
        .rs2_data_i      (v32_d2),
        .mem_reg_write_i (1'b0),
        .mem_rd_i        (5'd0),
        .mem_result_i    (v32_zero),
        .wb_reg_write_i  (1'b0),
        .wb_rd_i         (5'd0),
        .wb_result_i     (v32_zero),
        .valid_o         (v32_valid_o),
        .rd_o            (v32_rd_o),
        .alu_result_o    (v32_result),
        .wr_ram_data_o   (v32_wr_ram)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction for a single clock edge (ready_o assumed 1).
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic src, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] imm,
                         input logic [63:0] d1, input logic [63:0] d2);
        alu_op_i   = op;
        funct3_i   = f3;
        funct7_i   = f7;
        alu_src_i  = src;
        rs1_i      = s1;
        rs2_i      = s2;
        rd_i       = d;
        imm_i      = imm;
        rs1_data_i = d1;
        rs2_data_i = d2;
        valid_i    = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Counts cycles after capture until valid_o (cycle t+1 is 1); 999 on timeout.
    task automatic wait_valid(output int n, output int stalls);
        n      = 999;
        stalls = 0;
        for (int k = 1; k <= 200 && n == 999; k++) begin
            @(negedge clk);
            if (!ready_o) stalls++;
            if (valid_o) n = k;
        end
    endtask

    task automatic md_op(input string tag, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_n);
        int n;
        int st;
        issue(2'b10, f3, 7'b0000001, 1'b0, 5'd1, 5'd2, 5'd10, 32'd0, a, b);
        wait_valid(n, st);
        check({tag, "_result"}, alu_result_o, exp);
        check({tag, "_latency"}, 64'(n), 64'(exp_n));
        check({tag, "_stalls"}, 64'(st), 64'(exp_n - 1));
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        valid_i = 0; alu_src_i = 0; alu_op_i = 0; funct3_i = 0; funct7_i = 0;
        rs1_i = 0; rs2_i = 0; rd_i = 0; imm_i = 0; rs1_data_i = 0; rs2_data_i = 0;
        mem_we = 0; mem_rd = 0; mem_res = 0; wb_we = 0; wb_rd = 0; wb_res = 0;
        v32_valid_i = 0; v32_alu_src = 0; v32_alu_op = 0; v32_funct3 = 0; v32_funct7 = 0;
        v32_rs1 = 0; v32_rs2 = 0; v32_rd = 0; v32_imm = 0; v32_d1 = 0; v32_d2 = 0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_rd", 64'(rd_o), 64'd0);
        check("rst_result", alu_result_o, 64'd0);
        check("rst_wr_ram", wr_ram_data_o, 64'd0);

        // MEM beats WB beats register file
        mem_we = 1; mem_rd = 5; mem_res = 64'd10;
        wb_we  = 1; wb_rd  = 5; wb_res  = 64'd20;
        issue(2'b00, 3'b000, 7'd0, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0, 64'd1, 64'd3);
        @(negedge clk);
        check("fwd_valid", 64'(valid_o), 64'd1);
        check("fwd_result", alu_result_o, 64'd13);
        check("fwd_rd", 64'(rd_o), 64'd7);
        check("fwd_wr_ram", wr_ram_data_o, 64'd3);

        // SUB with rs2 from WB, MEM targets an unrelated register
        mem_rd = 3; mem_res = 64'd77;
        wb_rd  = 2; wb_res  = 64'd8;
        issue(2'b10, 3'b000, 7'b0100000, 1'b0, 5'd1, 5'd2, 5'd9, 32'd0, 64'd50, 64'd7);
        @(negedge clk);
        check("sub_wbfwd_result", alu_result_o, 64'd42);
        check("sub_wbfwd_wr_ram", wr_ram_data_o, 64'd8);

        // x0 never forwards
        mem_we = 1; mem_rd = 0; mem_res = 64'd99; wb_we = 0;
        issue(2'b00, 3'b000, 7'd0, 1'b1, 5'd0, 5'd0, 5'd3, 32'd4, 64'd0, 64'd0);
        @(negedge clk);
        check("x0_result", alu_result_o, 64'd4);
        mem_we = 0; mem_rd = 0; mem_res = 0; wb_rd = 0; wb_res = 0;

        // ADDI with a negative immediate, SRAI on a negative value
        issue(2'b11, 3'b000, 7'd0, 1'b1, 5'd1, 5'd0, 5'd4, 32'hFFFF_FFFD, 64'd10, 64'd0);
        @(negedge clk);
        check("addi_neg", alu_result_o, 64'd7);
        issue(2'b11, 3'b101, 7'b0100000, 1'b1, 5'd1, 5'd0, 5'd4, 32'h0000_0404,
              64'hF000_0000_0000_0000, 64'd0);
        @(negedge clk);
        check("srai", alu_result_o, 64'hFF00_0000_0000_0000);

        // M extension, XLEN=64
        md_op("mul",      3'b000, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        md_op("mulhu",    3'b011, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65);
        md_op("mulhsu",   3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        md_op("div_zero", 3'b100, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        md_op("rem_zero", 3'b110, 64'd100, 64'd0, 64'd100, 2);
        md_op("div_ovf",  3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 2);
        md_op("rem_ovf",  3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
        md_op("div_neg",  3'b100, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        md_op("rem_neg",  3'b110, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        md_op("divu",     3'b101, 64'd100, 64'd7, 64'd14, 65);

        // Reset in the middle of a DIVU
        issue(2'b10, 3'b101, 7'b0000001, 1'b0, 5'd1, 5'd2, 5'd11, 32'd0, 64'd1000, 64'd7);
        repeat (10) @(negedge clk);
        check("divu_busy_ready", 64'(ready_o), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_result", alu_result_o, 64'd0);
        issue(2'b00, 3'b000, 7'd0, 1'b0, 5'd1, 5'd2, 5'd12, 32'd0, 64'd2, 64'd2);
        @(negedge clk);
        check("midrst_add_valid", 64'(valid_o), 64'd1);
        check("midrst_add_result", alu_result_o, 64'd4);

        // MULHU on XLEN=32, then an ADD captured in the DONE cycle
        v32_alu_op = 2'b10; v32_funct3 = 3'b011; v32_funct7 = 7'b0000001;
        v32_rs1 = 5'd1; v32_rs2 = 5'd2; v32_rd = 5'd13;
        v32_d1 = 32'hFFFF_FFFF; v32_d2 = 32'hFFFF_FFFF;
        v32_valid_i = 1'b1;
        @(posedge clk);
        #1 v32_valid_i = 1'b0;
        n = 999;
        for (int k = 1; k <= 100 && n == 999; k++) begin
            @(negedge clk);
            if (v32_valid_o) n = k;
        end
        check("mulhu32_latency", 64'(n), 64'd33);
        check("mulhu32_result", 64'(v32_result), 64'h0000_0000_FFFF_FFFE);
        check("mulhu32_done_ready", 64'(v32_ready_o), 64'd1);
        v32_alu_op = 2'b00; v32_funct3 = 3'b000; v32_funct7 = 7'd0;
        v32_rd = 5'd14; v32_d1 = 32'd5; v32_d2 = 32'd6;
        v32_valid_i = 1'b1;
        @(posedge clk);
        #1 v32_valid_i = 1'b0;
        @(negedge clk);
        check("b2b_add_valid", 64'(v32_valid_o), 64'd1);
        check("b2b_add_result", 64'(v32_result), 64'd11);
        check("b2b_add_rd", 64'(v32_rd_o), 64'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
